// File: rtl/mycpu_data_sram_resp.sv
// Responder end of the CPU data-SRAM interface.
// Word-organised RAM with byte-lane writes and a configurable read latency.
// It also acts as a wait-state generator that exercises pipeline stalls.
// Out-of-range accesses raise a sticky error flag.
module mycpu_data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_busy,
    output logic        data_sram_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    // Refuse to elaborate with a latency the 3-bit counter cannot express.
    // The address width is also bounded so that the range-check slice stays non-empty.
    generate
        if (LATENCY < 1 || LATENCY > 7) begin : g_badLatency
            $error("mycpu_data_sram_resp: LATENCY must be in 1..7");
        end
        if (ADDR_W < 1 || ADDR_W > 29) begin : g_badAddrW
            $error("mycpu_data_sram_resp: ADDR_W must be in 1..29");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cntNext;
    logic [31:0]         r_mem [DEPTH];
    logic [31:0]         r_snap;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [ADDR_W-1:0]   w_index;
    logic                w_inRange;
    logic                w_busy;
    logic                w_accept;
    logic                w_readAcc;
    logic                w_writeAcc;
    logic [31:0]         w_readWord;
    logic                w_unusedAddrLsb;

    // Decode the request: the word index, the range check and whether it is taken this cycle.
    always_comb begin
        w_index         = data_sram_addr[ADDR_W+1:2];
        w_inRange       = (data_sram_addr[31:ADDR_W+2] == '0);
        w_unusedAddrLsb = ^data_sram_addr[1:0];
        w_busy          = (r_state == WAIT);
        w_accept        = data_sram_en && !w_busy;
        w_readAcc       = w_accept && (data_sram_wen == 4'b0000);
        w_writeAcc      = w_accept && (data_sram_wen != 4'b0000) && w_inRange;
        w_readWord      = w_inRange ? r_mem[w_index] : 32'h0000_0000;
    end

    // Apply an accepted in-range write to the enabled byte lanes only; reset blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && w_writeAcc) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    r_mem[w_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Capture the addressed word when a read is accepted so later writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= 32'h0000_0000;
        end else if (w_readAcc) begin
            r_snap <= w_readWord;
        end
    end

    // Hold the FSM state and the wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Choose the next state: a read goes to RESP directly at latency 1, otherwise through WAIT.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                w_stateNext = IDLE;
                if (w_readAcc) begin
                    if (LATENCY == 1) begin
                        w_stateNext = RESP;
                    end else begin
                        w_stateNext = WAIT;
                        w_cntNext   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_stateNext = RESP;
                    w_cntNext   = 3'd0;
                end else begin
                    w_cntNext = r_cnt - 3'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = 3'd0;
            end
        endcase
    end

    // Load the response word on the edge entering RESP, so it is valid with rvalid and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_stateNext == RESP) begin
            r_rdata <= (r_state == WAIT) ? r_snap : w_readWord;
        end
    end

    // Latch any accepted out-of-range access until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_inRange) begin
            r_err <= 1'b1;
        end
    end

    assign data_sram_rdata  = r_rdata;
    assign data_sram_rvalid = (r_state == RESP);
    assign data_sram_busy   = w_busy;
    assign data_sram_err    = r_err;

endmodule
